pipe_ctrl_decoder: RTL and testbench

//  ID-stage control unit for the pipelined CPU: decodes opcode/funct into the ID/EX control bundle.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/ctrl_decode_comb.sv | 68 ++++++
 rtl/pipe_ctrl_decoder.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared opcode/funct codes, ALU-op codes and the ID/EX control bundle type.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BGEZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_BNEZ  = 6'd37;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_BEQ   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_LUI   = 4'd3;
  localparam logic [3:0] ALU_SLTI  = 4'd4;
  localparam logic [3:0] ALU_BNE   = 4'd5;
  localparam logic [3:0] ALU_ORI   = 4'd7;
  localparam logic [3:0] ALU_LW    = 4'd8;
  localparam logic [3:0] ALU_SW    = 4'd9;
  localparam logic [3:0] ALU_J     = 4'd11;
  localparam logic [3:0] ALU_BGT   = 4'd12;
  localparam logic [3:0] ALU_BNEZ  = 4'd13;
  localparam logic [3:0] ALU_BGEZ  = 4'd14;
  localparam logic [3:0] ALU_JAL   = 4'd15;

  typedef enum logic [1:0] {
    REG_DST_RT  = 2'b00,
    REG_DST_RD  = 2'b01,
    REG_DST_R31 = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU = 2'b00,
    MEM_TO_REG_MEM = 2'b01,
    MEM_TO_REG_PC4 = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    logic        regWrite;
    logic [3:0]  aluOp;
    logic        aluSrc;
    reg_dst_e    regDst;
    logic        branch;
    logic        jump;
    logic        jr;
    logic        memRead;
    logic        memWrite;
    mem_to_reg_e memToReg;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purpose: pure opcode/funct decode into the control bundle plus illegal/uses-rt/MUL flags.
// Latency: combinational.
// Backpressure: none; the caller decides whether the decode is issued.
module ctrl_decode_comb
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         usesRt,
  output logic         isMul
);

  // Opcode table; unknown opcodes leave the bundle at bubble and flag illegal.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    usesRt  = 1'b0;
    isMul   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        usesRt     = 1'b1;
        ctrl.aluOp = ALU_RTYPE;
        if (funct == FUNCT_JR) begin
          ctrl.jump = 1'b1;
          ctrl.jr   = 1'b1;
        end else begin
          ctrl.regWrite = 1'b1;
          ctrl.regDst   = REG_DST_RD;
          isMul         = (funct == FUNCT_MUL);
        end
      end
      OP_BGEZ: begin ctrl.branch = 1'b1; ctrl.aluOp = ALU_BGEZ; end
      OP_J:    begin ctrl.jump = 1'b1; ctrl.aluOp = ALU_J; end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REG_DST_R31;
        ctrl.memToReg = MEM_TO_REG_PC4;
        ctrl.aluOp    = ALU_JAL;
      end
      OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.aluOp = ALU_BEQ; usesRt = 1'b1; end
      OP_BNE:  begin ctrl.branch = 1'b1; ctrl.aluOp = ALU_BNE; usesRt = 1'b1; end
      OP_BGT:  begin ctrl.branch = 1'b1; ctrl.aluOp = ALU_BGT; usesRt = 1'b1; end
      OP_ADDI: begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALU_ADD; end
      OP_SLTI: begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALU_SLTI; end
      OP_ORI:  begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALU_ORI; end
      OP_LUI:  begin ctrl.regWrite = 1'b1; ctrl.aluSrc = 1'b1; ctrl.aluOp = ALU_LUI; end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = MEM_TO_REG_MEM;
        ctrl.aluOp    = ALU_LW;
      end
      OP_BNEZ: begin ctrl.branch = 1'b1; ctrl.aluOp = ALU_BNEZ; end
      OP_SW: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
        ctrl.aluOp    = ALU_SW;
        usesRt        = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// Purpose: ID-stage control: decode, load-use bubbles, MUL sequencing, flush, ID/EX control register.
// Latency: 1 cycle from instr_i to the registered control outputs.
// Backpressure: stall_o (combinational) holds PC and IF/ID during load-use and MUL busy cycles.
module pipe_ctrl_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int RADDR_W = 5,
  parameter int MUL_LAT = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        instr_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic               idex_memread_i,
  input  logic [RADDR_W-1:0] idex_rt_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic               reg_write_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o,
  output logic [1:0]         reg_dst_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               jr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               illegal_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {ST_RUN, ST_MUL_BUSY} state_e;

  state_e       state, stateNext;
  logic [CNT_W-1:0] mulCnt, cntNext;
  ctrl_bundle_t decCtrl, issueCtrl, ctrlQ;
  logic         decIllegal, decUsesRt, decIsMul;
  logic         issueValid, issueIllegal, validQ, illegalQ;
  logic         loadUse;
  logic [RADDR_W-1:0] rsAddr, rtAddr;
  logic         unusedInstr;

  // rd/shamt are consumed downstream, not by this control unit.
  assign unusedInstr = ^instr_i[15:6];
  assign rsAddr = RADDR_W'(instr_i[25:21]);
  assign rtAddr = RADDR_W'(instr_i[20:16]);

  ctrl_decode_comb uDecode (
    .opcode  (instr_i[31:26]),
    .funct   (instr_i[5:0]),
    .ctrl    (decCtrl),
    .illegal (decIllegal),
    .usesRt  (decUsesRt),
    .isMul   (decIsMul)
  );

  // r0 is never a real load destination, so it cannot create a hazard.
  assign loadUse = valid_i && idex_memread_i && (idex_rt_i != '0) &&
                   ((idex_rt_i == rsAddr) || (decUsesRt && (idex_rt_i == rtAddr)));

  // Next state and issue selection: flush > MUL busy > load-use > issue.
  always_comb begin
    stateNext    = state;
    cntNext      = mulCnt;
    stall_o      = 1'b0;
    issueCtrl    = '0;
    issueValid   = 1'b0;
    issueIllegal = 1'b0;
    if (flush_i) begin
      stateNext = ST_RUN;
      cntNext   = '0;
    end else if (state == ST_MUL_BUSY) begin
      stall_o = 1'b1;
      cntNext = mulCnt - CNT_ONE;
      if (mulCnt == CNT_ONE) begin
        stateNext = ST_RUN;
      end
    end else if (loadUse) begin
      stall_o = 1'b1;
    end else if (valid_i) begin
      if (decIllegal) begin
        issueIllegal = 1'b1;
      end else begin
        issueValid = 1'b1;
        issueCtrl  = decCtrl;
        if (decIsMul && (MUL_LAT > 1)) begin
          stateNext = ST_MUL_BUSY;
          cntNext   = CNT_W'(MUL_LAT - 1);
        end
      end
    end
  end

  // FSM state and MUL countdown register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_RUN;
      mulCnt <= '0;
    end else begin
      state  <= stateNext;
      mulCnt <= cntNext;
    end
  end

  // ID/EX control register; a bubble is an all-zero bundle with valid low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrlQ    <= '0;
      validQ   <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      ctrlQ    <= issueCtrl;
      validQ   <= issueValid;
      illegalQ <= issueIllegal;
    end
  end

  assign valid_o      = validQ;
  assign reg_write_o  = ctrlQ.regWrite;
  assign alu_op_o     = ALUOP_W'(ctrlQ.aluOp);
  assign alu_src_o    = ctrlQ.aluSrc;
  assign reg_dst_o    = ctrlQ.regDst;
  assign branch_o     = ctrlQ.branch;
  assign jump_o       = ctrlQ.jump;
  assign jr_o         = ctrlQ.jr;
  assign mem_read_o   = ctrlQ.memRead;
  assign mem_write_o  = ctrlQ.memWrite;
  assign mem_to_reg_o = ctrlQ.memToReg;
  assign illegal_o    = illegalQ;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Purpose: directed stimulus with a behavioural model checked every cycle plus literal spot checks.
// Latency: model predicts registered outputs one edge ahead.
// Backpressure: stall_o checked against the model each cycle.
module tb_pipe_ctrl_decoder;

  localparam int ALUOP_W = 4;
  localparam int RADDR_W = 5;
  localparam int MUL_LAT = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_i = 1'b0;
  logic [31:0]        instr_i = 32'd0;
  logic               valid_i = 1'b0;
  logic               flush_i = 1'b0;
  logic               idex_memread_i = 1'b0;
  logic [RADDR_W-1:0] idex_rt_i = '0;
  logic               stall_o, valid_o, reg_write_o, alu_src_o, branch_o, jump_o, jr_o;
  logic               mem_read_o, mem_write_o, illegal_o;
  logic [ALUOP_W-1:0] alu_op_o;
  logic [1:0]         reg_dst_o, mem_to_reg_o;

  pipe_ctrl_decoder #(.ALUOP_W(ALUOP_W), .RADDR_W(RADDR_W), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i), .flush_i(flush_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i), .stall_o(stall_o),
    .valid_o(valid_o), .reg_write_o(reg_write_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
    .reg_dst_o(reg_dst_o), .branch_o(branch_o), .jump_o(jump_o), .jr_o(jr_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .illegal_o(illegal_o)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic [3:0] op;
    logic       src;
    logic [1:0] dst;
    logic       br;
    logic       jmp;
    logic       jr;
    logic       mr;
    logic       mw;
    logic [1:0] m2r;
    logic       ill;
  } out_t;

  // Expected control bundle straight from the instruction-set table.
  function automatic out_t modelDecode(input logic [5:0] op, input logic [5:0] fn);
    out_t r;
    r = '0;
    r.vld = 1'b1;
    case (op)
      6'd0:  if (fn == 6'h08) begin r.op = 2; r.jmp = 1; r.jr = 1; end
             else begin r.op = 2; r.rw = 1; r.dst = 2'b01; end
      6'd1:  begin r.br = 1; r.op = 14; end
      6'd2:  begin r.jmp = 1; r.op = 11; end
      6'd3:  begin r.jmp = 1; r.rw = 1; r.dst = 2'b10; r.m2r = 2'b10; r.op = 15; end
      6'd4:  begin r.br = 1; r.op = 1; end
      6'd5:  begin r.br = 1; r.op = 5; end
      6'd7:  begin r.br = 1; r.op = 12; end
      6'd8:  begin r.rw = 1; r.src = 1; r.op = 0; end
      6'd10: begin r.rw = 1; r.src = 1; r.op = 4; end
      6'd13: begin r.rw = 1; r.src = 1; r.op = 7; end
      6'd15: begin r.rw = 1; r.src = 1; r.op = 3; end
      6'd35: begin r.rw = 1; r.src = 1; r.mr = 1; r.m2r = 2'b01; r.op = 8; end
      6'd37: begin r.br = 1; r.op = 13; end
      6'd43: begin r.src = 1; r.mw = 1; r.op = 9; end
      default: begin r = '0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic bit readsRt(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd7) || (op == 6'd43);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  out_t expQ = '0;
  int   busyLeft = 0;

  // Compare process: check registered outputs and stall, then predict the next edge.
  always @(negedge clk_i) begin
    out_t d;
    bit lu, expStall;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    op = instr_i[31:26];
    fn = instr_i[5:0];
    rs = instr_i[25:21];
    rt = instr_i[20:16];
    if (!rst_i) begin
      expQ = '0;
      busyLeft = 0;
    end
    chk("valid_o", valid_o, expQ.vld);
    chk("reg_write_o", reg_write_o, expQ.rw);
    chk("alu_op_o", alu_op_o, expQ.op);
    chk("alu_src_o", alu_src_o, expQ.src);
    chk("reg_dst_o", reg_dst_o, expQ.dst);
    chk("branch_o", branch_o, expQ.br);
    chk("jump_o", jump_o, expQ.jmp);
    chk("jr_o", jr_o, expQ.jr);
    chk("mem_read_o", mem_read_o, expQ.mr);
    chk("mem_write_o", mem_write_o, expQ.mw);
    chk("mem_to_reg_o", mem_to_reg_o, expQ.m2r);
    chk("illegal_o", illegal_o, expQ.ill);
    lu = valid_i && idex_memread_i && (idex_rt_i != 0) &&
         ((idex_rt_i == rs) || (readsRt(op) && (idex_rt_i == rt)));
    if (flush_i) expStall = 1'b0;
    else if (busyLeft > 0) expStall = 1'b1;
    else expStall = lu;
    chk("stall_o", stall_o, expStall);
    if (rst_i) begin
      if (flush_i) begin
        expQ = '0;
        busyLeft = 0;
      end else if (busyLeft > 0) begin
        expQ = '0;
        busyLeft--;
      end else if (lu || !valid_i) begin
        expQ = '0;
      end else begin
        d = modelDecode(op, fn);
        expQ = d;
        if (op == 6'd0 && fn == 6'h18) busyLeft = MUL_LAT - 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int ops[9];
    ops = '{1, 2, 4, 5, 7, 10, 15, 37, 43};

    // 1: reset with LW pending, then first issue.
    instr_i = itype(6'd35, 5'd1, 5'd2, 16'h0010);
    valid_i = 1'b1;
    tick(); tick();
    chk("lit_rst_valid", valid_o, 0);
    chk("lit_rst_memread", mem_read_o, 0);
    chk("lit_rst_stall", stall_o, 0);
    rst_i = 1'b1;
    tick();
    chk("lit_lw_memread", mem_read_o, 1);
    chk("lit_lw_m2r", mem_to_reg_o, 2'b01);
    chk("lit_lw_aluop", alu_op_o, 8);
    chk("lit_lw_valid", valid_o, 1);

    // 2: load-use on rs.
    instr_i = rtype(5'd5, 5'd6, 5'd7, 6'h20);
    idex_memread_i = 1'b1;
    idex_rt_i = 5'd5;
    #1 chk("lit_lu_stall", stall_o, 1);
    tick();
    chk("lit_lu_bubble", valid_o, 0);
    idex_memread_i = 1'b0;
    #1 chk("lit_lu_release", stall_o, 0);
    tick();
    chk("lit_add_aluop", alu_op_o, 2);
    chk("lit_add_regdst", reg_dst_o, 2'b01);
    chk("lit_add_valid", valid_o, 1);

    // Hazard boundaries: r0 destination, SW reading rt, LW not reading rt.
    idex_memread_i = 1'b1;
    idex_rt_i = 5'd0;
    instr_i = itype(6'd8, 5'd0, 5'd3, 16'h0001);
    #1 chk("lit_r0_nostall", stall_o, 0);
    tick();
    idex_rt_i = 5'd4;
    instr_i = itype(6'd43, 5'd1, 5'd4, 16'h0004);
    #1 chk("lit_sw_rt_stall", stall_o, 1);
    tick();
    instr_i = itype(6'd35, 5'd1, 5'd4, 16'h0004);
    #1 chk("lit_lw_rt_nostall", stall_o, 0);
    tick();
    idex_memread_i = 1'b0;

    // 3: MUL occupies EX for MUL_LAT cycles.
    instr_i = rtype(5'd1, 5'd2, 5'd3, 6'h18);
    tick();
    chk("lit_mul_valid", valid_o, 1);
    instr_i = itype(6'd8, 5'd1, 5'd9, 16'h0002);
    #1 chk("lit_mul_stall1", stall_o, 1);
    tick();
    chk("lit_mul_bub1", valid_o, 0);
    chk("lit_mul_stall2", stall_o, 1);
    tick();
    chk("lit_mul_bub2", valid_o, 0);
    chk("lit_mul_free", stall_o, 0);
    tick();
    chk("lit_addi_valid", valid_o, 1);
    chk("lit_addi_src", alu_src_o, 1);

    // 4: flush during the first MUL busy cycle.
    instr_i = rtype(5'd1, 5'd2, 5'd3, 6'h18);
    tick();
    instr_i = itype(6'd13, 5'd2, 5'd8, 16'h00ff);
    flush_i = 1'b1;
    #1 chk("lit_flush_stall", stall_o, 0);
    tick();
    chk("lit_flush_bubble", valid_o, 0);
    flush_i = 1'b0;
    #1 chk("lit_after_flush_stall", stall_o, 0);
    tick();
    chk("lit_ori_valid", valid_o, 1);
    chk("lit_ori_aluop", alu_op_o, 7);

    // 5: illegal opcode with and without valid.
    instr_i = {6'h3f, 26'h0};
    tick();
    chk("lit_ill_pulse", illegal_o, 1);
    chk("lit_ill_valid", valid_o, 0);
    valid_i = 1'b0;
    tick();
    chk("lit_ill_novalid", illegal_o, 0);
    valid_i = 1'b1;

    // 6: JAL then JR.
    instr_i = {6'd3, 26'h0000040};
    tick();
    chk("lit_jal_regdst", reg_dst_o, 2'b10);
    chk("lit_jal_m2r", mem_to_reg_o, 2'b10);
    chk("lit_jal_jump", jump_o, 1);
    instr_i = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    tick();
    chk("lit_jr_jump", jump_o, 1);
    chk("lit_jr_jr", jr_o, 1);
    chk("lit_jr_regwrite", reg_write_o, 0);

    // Remaining opcodes, checked by the model.
    for (int i = 0; i < 9; i++) begin
      instr_i = itype(6'(ops[i]), 5'd3, 5'd4, 16'h1234);
      tick();
    end

    // Reset in the middle of a MUL.
    instr_i = rtype(5'd1, 5'd2, 5'd3, 6'h18);
    tick();
    rst_i = 1'b0;
    #1 chk("lit_midmul_valid", valid_o, 0);
    chk("lit_midmul_stall", stall_o, 0);
    tick();
    rst_i = 1'b1;
    instr_i = itype(6'd8, 5'd1, 5'd2, 16'h0003);
    tick();
    chk("lit_post_reset_issue", valid_o, 1);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
